// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

    localparam logic [6:0] I2C_DEV_ADDR = 7'h3C;
    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_REG_H,
        ST_REG_H_ACK,
        ST_REG_L,
        ST_REG_L_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_BYTE,
        ST_RD_MACK,
        ST_WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, glitch filter and edge pulses for one bus line
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic line_i,
    output logic line_f,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   line_d;
    logic                   line_s;

    assign line_s = sync_q[SYNC_STAGES-1];

    // Bring the pad into the clock domain; idle bus level is high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            line_f <= 1'b1;
            cnt_q  <= '0;
        end else if (line_s == line_f) begin
            cnt_q  <= '0;
        end else if (cnt_q == CW'(FILT_LEN - 1)) begin
            line_f <= line_s;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // Delayed copy of the filtered line for edge pulses.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) line_d <= 1'b1;
        else        line_d <= line_f;
    end

    assign rise = line_f & ~line_d;
    assign fall = ~line_f & line_d;

endmodule

// File: rtl/i2c_slave_resp.sv
// rtl/i2c_slave_resp.sv - I2C target with 16-bit register pointer and auto-increment
module i2c_slave_resp
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        err
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i(clk_i), .rst_n(rst_n), .line_i(scl_i),
        .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i(clk_i), .rst_n(rst_n), .line_i(sda_i),
        .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d, tx_q, tx_d;
    logic        phase_q, phase_d;
    logic        rw_q, rw_d;
    logic [1:0]  ld_step_q, ld_step_d;
    logic        sda_oe_d, wr_en_d, rd_req_d, busy_d, err_d;
    logic [15:0] reg_addr_d;
    logic [7:0]  wr_data_d;
    logic [7:0]  rx_byte;
    logic        start_det, stop_det;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign rx_byte   = {rx_q[6:0], sda_f};

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            ld_step_q <= '0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            ld_step_q <= ld_step_d;
            sda_oe    <= sda_oe_d;
            reg_addr  <= reg_addr_d;
            wr_en     <= wr_en_d;
            wr_data   <= wr_data_d;
            rd_req    <= rd_req_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    // Protocol sequencing; START/STOP take priority over any bit activity.
    // phase_q marks the second half of an ACK slot (or the last bit of a read byte).
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        ld_step_d  = ld_step_q;
        sda_oe_d   = sda_oe;
        reg_addr_d = reg_addr;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data;
        rd_req_d   = 1'b0;
        busy_d     = busy;
        err_d      = err;

        if (start_det) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            if (state_q inside {ST_RD_LOAD, ST_RD_BYTE, ST_RD_MACK}) err_d = 1'b1;
        end else begin
            case (state_q)
                ST_DEV, ST_REG_H, ST_REG_L, ST_WR_BYTE: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_d = ST_DEV_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                        err_d   = 1'b0;
                                    end else begin
                                        state_d = ST_WAIT_STOP;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_REG_H: begin
                                    reg_addr_d[15:8] = rx_byte;
                                    state_d          = ST_REG_H_ACK;
                                end
                                ST_REG_L: begin
                                    reg_addr_d[7:0] = rx_byte;
                                    state_d         = ST_REG_L_ACK;
                                end
                                default: begin
                                    wr_data_d = rx_byte;
                                    wr_en_d   = 1'b1;
                                    state_d   = ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_DEV_ACK, ST_REG_H_ACK, ST_REG_L_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            case (state_q)
                                ST_DEV_ACK:   state_d = ST_REG_H;
                                ST_REG_H_ACK: state_d = ST_REG_L;
                                ST_REG_L_ACK: state_d = ST_WR_BYTE;
                                default: begin
                                    reg_addr_d = reg_addr + 16'd1;
                                    state_d    = ST_WR_BYTE;
                                end
                            endcase
                        end
                    end else if (scl_rise) begin
                        // Reads start loading during the ACK high phase so the first bit is ready at the fall.
                        if (state_q == ST_DEV_ACK && rw_q) begin
                            state_d   = ST_RD_LOAD;
                            ld_step_d = '0;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end
                end
                ST_RD_LOAD: begin
                    case (ld_step_q)
                        2'd0: begin
                            rd_req_d  = 1'b1;
                            ld_step_d = 2'd1;
                        end
                        2'd1: ld_step_d = 2'd2;
                        2'd2: begin
                            tx_d      = rd_data;
                            ld_step_d = 2'd3;
                        end
                        default: begin
                            if (scl_fall) begin
                                sda_oe_d  = ~tx_q[7];
                                bit_cnt_d = '0;
                                phase_d   = 1'b0;
                                state_d   = ST_RD_BYTE;
                            end
                        end
                    endcase
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) phase_d = 1'b1;
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_RD_MACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_rise) begin
                        if (sda_f == ACK) begin
                            reg_addr_d = reg_addr + 16'd1;
                            ld_step_d  = '0;
                            state_d    = ST_RD_LOAD;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_resp.sv
// tb/tb_i2c_slave_resp.sv - directed bench for i2c_slave_resp
module tb_i2c_slave_resp;

    localparam int Q = 10;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [7:0]  rd_data = 8'h00;
    logic        busy;
    logic        err;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_resp #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(rd_data), .busy(busy), .err(err)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] bank_val(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h5A;
            16'h0011: return 8'hC3;
            default:  return 8'hFF;
        endcase
    endfunction

    always @(posedge clk_i) if (rd_req) rd_data <= bank_val(reg_addr);

    logic [23:0] wr_log[$];
    logic [15:0] rd_log[$];
    int          oe_cnt = 0;

    always @(negedge clk_i) begin
        if (wr_en)  wr_log.push_back({reg_addr, wr_data});
        if (rd_req) rd_log.push_back(reg_addr);
        if (sda_oe) oe_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic bit_xfer(input logic b, input logic glitch, output logic s);
        sda_m = b;
        tick(Q / 2);
        if (glitch) begin
            scl_m = 1'b1; tick(1);
            scl_m = 1'b0;
        end
        tick(Q / 2);
        scl_m = 1'b1; tick(Q);
        s = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], i == glitch_bit, s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(mack, 1'b0, s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        logic       s;
        int         wb, rb, ob;

        tick(5);
        check("rst_sda_oe",   32'(sda_oe),   32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_wr_en",    32'(wr_en),    32'h0);
        check("rst_rd_req",   32'(rd_req),   32'h0);
        check("rst_wr_data",  32'(wr_data),  32'h0);
        rst_n = 1'b1;
        tick(Q);

        // single write to 0x1234
        wb = wr_log.size();
        i2c_start();
        write_byte(8'h78, 8, a); check("t1_dev_ack", 32'(a), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        write_byte(8'h12, 8, a); check("t1_regh_ack", 32'(a), 32'h0);
        write_byte(8'h34, 8, a); check("t1_regl_ack", 32'(a), 32'h0);
        write_byte(8'hA5, 8, a); check("t1_data_ack", 32'(a), 32'h0);
        check("t1_wr_cnt", 32'(wr_log.size() - wb), 32'd1);
        check("t1_wr",     32'(wr_log[wb]),         32'h1234A5);
        check("t1_ptr",    32'(reg_addr),           32'h1235);
        i2c_stop(); tick(Q);
        check("t1_busy_stop", 32'(busy), 32'h0);

        // pointer wrap at 0xFFFF
        wb = wr_log.size();
        i2c_start();
        write_byte(8'h78, 8, a);
        write_byte(8'hFF, 8, a);
        write_byte(8'hFF, 8, a);
        write_byte(8'h11, 8, a);
        write_byte(8'h22, 8, a); check("t2_ack", 32'(a), 32'h0);
        i2c_stop(); tick(Q);
        check("t2_wr_cnt", 32'(wr_log.size() - wb), 32'd2);
        check("t2_wr0",    32'(wr_log[wb]),         32'hFFFF11);
        check("t2_wr1",    32'(wr_log[wb + 1]),     32'h000022);

        // random read via repeated START
        wb = wr_log.size();
        rb = rd_log.size();
        i2c_start();
        write_byte(8'h78, 8, a);
        write_byte(8'h00, 8, a);
        write_byte(8'h10, 8, a);
        i2c_start();
        write_byte(8'h79, 8, a); check("t3_dev_ack", 32'(a), 32'h0);
        read_byte(1'b0, d); check("t3_rd0", 32'(d), 32'h5A);
        read_byte(1'b1, d); check("t3_rd1", 32'(d), 32'hC3);
        i2c_stop(); tick(Q);
        check("t3_rd_cnt", 32'(rd_log.size() - rb), 32'd2);
        check("t3_rd_a0",  32'(rd_log[rb]),         32'h0010);
        check("t3_rd_a1",  32'(rd_log[rb + 1]),     32'h0011);
        check("t3_err",    32'(err),                32'h0);
        check("t3_wr_cnt", 32'(wr_log.size() - wb), 32'd0);

        // read aborted by STOP after an ACK sets err
        i2c_start();
        write_byte(8'h79, 8, a);
        read_byte(1'b0, d); check("t3b_rd", 32'(d), 32'hC3);
        i2c_stop(); tick(Q);
        check("t3b_err", 32'(err), 32'h1);

        // address mismatch
        wb = wr_log.size();
        rb = rd_log.size();
        ob = oe_cnt;
        i2c_start();
        write_byte(8'h7A, 8, a); check("t4_nack", 32'(a), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);
        write_byte(8'h00, 8, a);
        check("t4_err_sticky", 32'(err), 32'h1);
        i2c_stop(); tick(Q);
        check("t4_oe_cnt", 32'(oe_cnt - ob),         32'd0);
        check("t4_wr_cnt", 32'(wr_log.size() - wb), 32'd0);
        check("t4_rd_cnt", 32'(rd_log.size() - rb), 32'd0);

        // SCL glitch mid-byte, then STOP inside REG_L
        wb = wr_log.size();
        i2c_start();
        write_byte(8'h78, 8, a); check("t5_dev_ack", 32'(a), 32'h0);
        check("t5_err_clr", 32'(err), 32'h0);
        write_byte(8'h56, 4, a); check("t5_regh_ack", 32'(a), 32'h0);
        check("t5_ptr_h", 32'(reg_addr), 32'h5612);
        bit_xfer(1'b1, 1'b0, s);
        bit_xfer(1'b0, 1'b0, s);
        bit_xfer(1'b1, 1'b0, s);
        i2c_stop(); tick(Q);
        check("t5_busy",   32'(busy),               32'h0);
        check("t5_sda_oe", 32'(sda_oe),             32'h0);
        check("t5_ptr",    32'(reg_addr),           32'h5612);
        check("t5_wr_cnt", 32'(wr_log.size() - wb), 32'd0);

        // asynchronous reset during an ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'h78 >> i) & 8'h01) != 0, 1'b0, s);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q / 2);
        check("t6_oe_ack", 32'(sda_oe), 32'h1);
        check("t6_busy",   32'(busy),   32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_oe_async", 32'(sda_oe), 32'h0);
        tick(3);
        check("t6_rst_busy", 32'(busy),     32'h0);
        check("t6_rst_ptr",  32'(reg_addr), 32'h0);
        rst_n = 1'b1;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        wb = wr_log.size();
        i2c_start();
        write_byte(8'h78, 8, a); check("t6_dev_ack", 32'(a), 32'h0);
        write_byte(8'hAB, 8, a);
        write_byte(8'hCD, 8, a);
        write_byte(8'h99, 8, a); check("t6_data_ack", 32'(a), 32'h0);
        i2c_stop(); tick(Q);
        check("t6_wr_cnt", 32'(wr_log.size() - wb), 32'd1);
        check("t6_wr",     32'(wr_log[wb]),         32'hABCD99);
        check("t6_ptr",    32'(reg_addr),           32'hABCE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
